// File: rtl/pricing_pkg.sv
// Purpose : shared types and constants for the pricing scheduler.
// Contents: FSM state enum, result error codes, Q16.16 unity constant.
package pricing_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_BADOP   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic [31:0] ONE_Q16 = 32'h0001_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : combinational round-robin arbiter; grants the first active
//           request at or after the pointer, wrapping.
// Ports   : i_req   - request vector
//           i_ptr   - highest-priority requester index
//           o_grant - one-hot grant (zero when no request)
//           o_idx   - encoded grant index
//           o_any   - at least one request present
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IW-1:0]   o_idx,
   output logic            o_any
);

   // Walk the requesters starting at the pointer; the first hit wins.
   always_comb begin
      logic [IW-1:0] w_idx;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         w_idx = IW'((int'(i_ptr) + i) % int'(NREQ));
         if (!o_any && i_req[w_idx]) begin
            o_any          = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_idx          = w_idx;
         end
      end
   end

endmodule

// File: rtl/pricing_scheduler.sv
// Purpose : shares one start/done Black-Scholes pricer among NREQ requesters.
//           Round-robin accept, operand latch and screen, start/done
//           sequencing with timeout, tagged result handshake.
// Ports   : clk, reset_n (async, active-low)
//           req_*      - per-requester valid, packed Q16.16 operands, type
//           req_ready  - one-hot accept pulse (combinational, IDLE only)
//           pr_*       - pricer start pulse, latched operands, done/price
//           res_*      - result valid/ready handshake, id, price, error
//           busy       - scheduler not idle
module pricing_scheduler
   import pricing_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_rate,
   input  logic [NREQ*WIDTH-1:0]   req_timetm,
   input  logic [NREQ*WIDTH-1:0]   req_spot,
   input  logic [NREQ*WIDTH-1:0]   req_strike,
   input  logic [NREQ*WIDTH-1:0]   req_nd1,
   input  logic [NREQ*WIDTH-1:0]   req_nd2,
   input  logic [NREQ-1:0]         req_otype,
   output logic                    pr_start,
   output logic [WIDTH-1:0]        pr_rate,
   output logic [WIDTH-1:0]        pr_timetm,
   output logic [WIDTH-1:0]        pr_spot,
   output logic [WIDTH-1:0]        pr_strike,
   output logic [WIDTH-1:0]        pr_nd1,
   output logic [WIDTH-1:0]        pr_nd2,
   output logic                    pr_otype,
   input  logic                    pr_done,
   input  logic [WIDTH-1:0]        pr_price,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [$clog2(NREQ)-1:0] res_id,
   output logic [WIDTH-1:0]        res_price,
   output logic [1:0]              res_err,
   output logic                    busy
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic signed [WIDTH-1:0] ZERO_Q = '0;
   localparam logic signed [WIDTH-1:0] ONE_Q  = WIDTH'(ONE_Q16);

   state_t r_state, w_next;
   logic   w_accept;

   logic [NREQ-1:0] w_grant;
   logic [IW-1:0]   w_gidx;
   logic            w_any;

   logic [WIDTH-1:0] w_sel_rate, w_sel_timetm, w_sel_spot;
   logic [WIDTH-1:0] w_sel_strike, w_sel_nd1, w_sel_nd2;
   logic             w_sel_otype;
   logic             w_bad;

   logic [IW-1:0]    r_rr_ptr, r_job_id;
   logic [WIDTH-1:0] r_rate, r_timetm, r_spot, r_strike, r_nd1, r_nd2;
   logic             r_otype, r_badop;
   logic [CW-1:0]    r_cnt;
   logic             w_cnt_hit;
   logic             r_pr_start, r_res_valid, r_busy;
   logic [WIDTH-1:0] r_res_price;
   logic [1:0]       r_res_err;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_gidx),
      .o_any   (w_any)
   );

   // Operand mux for the winning requester.
   always_comb begin
      w_sel_rate   = '0;
      w_sel_timetm = '0;
      w_sel_spot   = '0;
      w_sel_strike = '0;
      w_sel_nd1    = '0;
      w_sel_nd2    = '0;
      w_sel_otype  = req_otype[w_gidx];
      for (int i = 0; i < int'(NREQ); i++) begin
         if (w_gidx == IW'(i)) begin
            w_sel_rate   = req_rate[i*WIDTH +: WIDTH];
            w_sel_timetm = req_timetm[i*WIDTH +: WIDTH];
            w_sel_spot   = req_spot[i*WIDTH +: WIDTH];
            w_sel_strike = req_strike[i*WIDTH +: WIDTH];
            w_sel_nd1    = req_nd1[i*WIDTH +: WIDTH];
            w_sel_nd2    = req_nd2[i*WIDTH +: WIDTH];
         end
      end
   end

   // Screen computed alongside the latch so the verdict is registered with the job.
   assign w_bad = ($signed(w_sel_timetm) <= ZERO_Q) ||
                  ($signed(w_sel_spot)   <= ZERO_Q) ||
                  ($signed(w_sel_strike) <= ZERO_Q) ||
                  ($signed(w_sel_nd1) < ZERO_Q) || ($signed(w_sel_nd1) > ONE_Q) ||
                  ($signed(w_sel_nd2) < ZERO_Q) || ($signed(w_sel_nd2) > ONE_Q);

   // Last WAIT cycle before abort; a done in this cycle still wins.
   assign w_cnt_hit = (r_cnt == CW'(TIMEOUT - 1));

   // Next-state logic.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_accept = 1'b1;
               w_next   = ST_ISSUE;
            end
         end
         ST_ISSUE: w_next = r_badop ? ST_HOLD : ST_WAIT;
         ST_WAIT:  if (pr_done || w_cnt_hit) w_next = ST_HOLD;
         ST_HOLD:  if (res_ready) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   assign req_ready = w_accept ? w_grant : '0;

   // State, job registers, timeout counter and result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_job_id    <= '0;
         r_rate      <= '0;
         r_timetm    <= '0;
         r_spot      <= '0;
         r_strike    <= '0;
         r_nd1       <= '0;
         r_nd2       <= '0;
         r_otype     <= 1'b0;
         r_badop     <= 1'b0;
         r_cnt       <= '0;
         r_pr_start  <= 1'b0;
         r_res_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_res_price <= '0;
         r_res_err   <= ERR_OK;
      end else begin
         r_state     <= w_next;
         r_pr_start  <= w_accept && !w_bad;
         r_res_valid <= (w_next == ST_HOLD);
         r_busy      <= (w_next != ST_IDLE);
         if (w_accept) begin
            r_job_id <= w_gidx;
            r_rate   <= w_sel_rate;
            r_timetm <= w_sel_timetm;
            r_spot   <= w_sel_spot;
            r_strike <= w_sel_strike;
            r_nd1    <= w_sel_nd1;
            r_nd2    <= w_sel_nd2;
            r_otype  <= w_sel_otype;
            r_badop  <= w_bad;
            r_rr_ptr <= (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + IW'(1);
         end
         case (r_state)
            ST_ISSUE: begin
               r_cnt <= '0;
               if (r_badop) begin
                  r_res_err   <= ERR_BADOP;
                  r_res_price <= '0;
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt + CW'(1);
               if (pr_done) begin
                  r_res_err   <= ERR_OK;
                  r_res_price <= pr_price;
               end else if (w_cnt_hit) begin
                  r_res_err   <= ERR_TIMEOUT;
                  r_res_price <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign pr_start  = r_pr_start;
   assign pr_rate   = r_rate;
   assign pr_timetm = r_timetm;
   assign pr_spot   = r_spot;
   assign pr_strike = r_strike;
   assign pr_nd1    = r_nd1;
   assign pr_nd2    = r_nd2;
   assign pr_otype  = r_otype;
   assign res_valid = r_res_valid;
   assign res_id    = r_job_id;
   assign res_price = r_res_price;
   assign res_err   = r_res_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_pricing_scheduler.sv
// Purpose : directed self-checking bench for pricing_scheduler with a
//           behavioural start/done pricer model.
module tb_pricing_scheduler;

   localparam int unsigned W  = 32;
   localparam int unsigned NR = 4;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_ready;
   logic [NR*W-1:0] req_rate = '0, req_timetm = '0, req_spot = '0;
   logic [NR*W-1:0] req_strike = '0, req_nd1 = '0, req_nd2 = '0;
   logic [NR-1:0]   req_otype = '0;
   logic            pr_start;
   logic [W-1:0]    pr_rate, pr_timetm, pr_spot, pr_strike, pr_nd1, pr_nd2;
   logic            pr_otype;
   logic            pr_done;
   logic [W-1:0]    pr_price;
   logic            res_valid;
   logic            res_ready = 1'b0;
   logic [1:0]      res_id;
   logic [W-1:0]    res_price;
   logic [1:0]      res_err;
   logic            busy;

   // Pricer model: done pulse m_delay cycles after start (0 = never).
   int           m_delay = 5;
   int           m_cnt = 0;
   logic         m_done = 1'b0;
   logic         s_done = 1'b0;
   logic [W-1:0] m_price = 32'h0045_0000;
   int           start_cnt = 0;

   int checks = 0;
   int errors = 0;

   assign pr_done  = m_done | s_done;
   assign pr_price = pr_done ? m_price : 32'hDEAD_BEEF;

   pricing_scheduler #(.WIDTH(W), .NREQ(NR), .TIMEOUT(64)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rate(req_rate), .req_timetm(req_timetm), .req_spot(req_spot),
      .req_strike(req_strike), .req_nd1(req_nd1), .req_nd2(req_nd2),
      .req_otype(req_otype),
      .pr_start(pr_start), .pr_rate(pr_rate), .pr_timetm(pr_timetm),
      .pr_spot(pr_spot), .pr_strike(pr_strike), .pr_nd1(pr_nd1),
      .pr_nd2(pr_nd2), .pr_otype(pr_otype),
      .pr_done(pr_done), .pr_price(pr_price),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
      .res_price(res_price), .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) m_done <= 1'b1;
      end
      if (pr_start) begin
         start_cnt <= start_cnt + 1;
         if (m_delay == 1) m_done <= 1'b1;
         else if (m_delay > 1) m_cnt <= m_delay - 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hs();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic wait_res(output int n);
      n = 0;
      while (res_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] rate, input logic [31:0] tt,
                          input logic [31:0] spot, input logic [31:0] strike,
                          input logic [31:0] nd1, input logic [31:0] nd2, input logic ot);
      req_rate[i*W +: W]   = rate;
      req_timetm[i*W +: W] = tt;
      req_spot[i*W +: W]   = spot;
      req_strike[i*W +: W] = strike;
      req_nd1[i*W +: W]    = nd1;
      req_nd2[i*W +: W]    = nd2;
      req_otype[i]         = ot;
   endtask

   task automatic set_good(input int i);
      set_req(i, 32'd3277, 32'd65536, 32'd6553600, 32'd6553600, 32'd43690, 32'd32768, 1'b0);
   endtask

   initial begin
      int n;
      int last_g;
      int s0;
      int exp_seq[5];
      exp_seq = '{0, 1, 2, 3, 0};
      for (int i = 0; i < int'(NR); i++) set_good(i);

      // Reset state
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_pr_start", pr_start, 0);
      chk("rst_pr_spot", pr_spot, 0);
      chk("rst_res_err", res_err, 0);
      #19 reset_n = 1'b1;
      tick();

      // Round-robin with all requesters active
      m_delay   = 3;
      res_ready = 1'b1;
      req_valid = 4'hF;
      last_g    = -1;
      for (int j = 0; j < 5; j++) begin
         n = 0;
         #1;
         while (req_ready == '0 && n < 50) begin
            if (res_valid) begin
               chk("rr_res_id", res_id, last_g[1:0]);
               chk("rr_res_price", res_price, 32'h0045_0000);
            end
            tick();
            n++;
         end
         chk("rr_wait_bound", n < 50, 1);
         chk("rr_grant", req_ready, 4'b0001 << exp_seq[j]);
         last_g = exp_seq[j];
         tick();
      end
      req_valid = '0;
      wait_res(n);
      chk("rr_last_res_id", res_id, 0);
      tick();
      res_ready = 1'b0;

      // Single request from requester 2, done 5 cycles after start
      m_delay   = 5;
      req_valid = 4'b0100;
      #1;
      chk("t1_ready", req_ready, 4'b0100);
      chk("t1_busy_idle", busy, 0);
      tick();
      req_valid = '0;
      chk("t1_pr_start", pr_start, 1);
      chk("t1_pr_spot", pr_spot, 32'd6553600);
      chk("t1_pr_nd1", pr_nd1, 32'd43690);
      chk("t1_busy", busy, 1);
      wait_res(n);
      chk("t1_latency", n, 6);
      chk("t1_res_id", res_id, 2);
      chk("t1_res_price", res_price, 32'h0045_0000);
      chk("t1_res_err", res_err, 0);

      // Stall in HOLD while requester 3 waits
      set_req(3, 32'd3277, 32'd65536, 32'd6553600, 32'd6553600, 32'd43690, 32'd32768, 1'b1);
      req_valid = 4'b1000;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("hold_ready", req_ready, 0);
         chk("hold_valid", res_valid, 1);
         chk("hold_id", res_id, 2);
         chk("hold_price", res_price, 32'h0045_0000);
         chk("hold_err", res_err, 0);
         tick();
      end
      res_ready = 1'b1;
      #1;
      chk("hs_cycle_ready", req_ready, 0);
      m_delay = 2;
      tick();
      res_ready = 1'b0;
      #1;
      chk("post_hs_valid", res_valid, 0);
      chk("post_hs_ready", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      chk("t5_pr_start", pr_start, 1);
      chk("t5_pr_otype", pr_otype, 1);
      wait_res(n);
      chk("t5_latency", n, 3);
      chk("t5_res_id", res_id, 3);
      hs();

      // Bad operand: requester 1 with spot = 0
      set_req(1, 32'd3277, 32'd65536, 32'd0, 32'd6553600, 32'd43690, 32'd32768, 1'b0);
      s0 = start_cnt;
      req_valid = 4'b0010;
      #1;
      chk("bad_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      chk("bad_no_start", pr_start, 0);
      chk("bad_not_valid_t1", res_valid, 0);
      tick();
      chk("bad_valid_t2", res_valid, 1);
      chk("bad_err", res_err, 2'b01);
      chk("bad_price", res_price, 0);
      chk("bad_id", res_id, 1);
      chk("bad_start_cnt", start_cnt, s0);
      hs();
      set_good(1);

      // Nd2 just above one is rejected
      set_req(2, 32'd3277, 32'd65536, 32'd6553600, 32'd6553600, 32'h0001_0000, 32'h0001_0001, 1'b0);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      chk("nd_no_start", pr_start, 0);
      tick();
      chk("nd_valid", res_valid, 1);
      chk("nd_err", res_err, 2'b01);
      chk("nd_id", res_id, 2);
      hs();
      set_good(2);

      // Timeout with boundary-valid Nd values (1.0 and 0)
      set_req(0, 32'd3277, 32'd65536, 32'd6553600, 32'd6553600, 32'h0001_0000, 32'd0, 1'b0);
      m_delay   = 0;
      req_valid = 4'b0001;
      #1;
      chk("to_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      chk("to_pr_start", pr_start, 1);
      wait_res(n);
      chk("to_latency", n, 65);
      chk("to_err", res_err, 2'b10);
      chk("to_price", res_price, 0);
      chk("to_id", res_id, 0);
      s_done = 1'b1;
      tick();
      s_done = 1'b0;
      chk("late_done_valid", res_valid, 1);
      chk("late_done_err", res_err, 2'b10);
      chk("late_done_price", res_price, 0);
      hs();
      s_done = 1'b1;
      tick();
      s_done = 1'b0;
      chk("idle_done_busy", busy, 0);
      chk("idle_done_valid", res_valid, 0);
      set_good(0);

      // Next job after timeout proceeds normally
      m_delay   = 4;
      m_price   = 32'h0012_3456;
      req_valid = 4'b0010;
      #1;
      chk("nx_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      chk("nx_pr_start", pr_start, 1);
      wait_res(n);
      chk("nx_latency", n, 5);
      chk("nx_price", res_price, 32'h0012_3456);
      chk("nx_err", res_err, 0);
      chk("nx_id", res_id, 1);
      hs();

      // Reset during WAIT
      m_delay   = 0;
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      tick();
      tick();
      chk("rw_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("rw_busy0", busy, 0);
      chk("rw_res_valid", res_valid, 0);
      chk("rw_pr_spot", pr_spot, 0);
      chk("rw_pr_nd1", pr_nd1, 0);
      chk("rw_res_id", res_id, 0);
      chk("rw_res_err", res_err, 0);
      chk("rw_res_price", res_price, 0);
      #10 reset_n = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         chk("rw_no_result", res_valid, 0);
         tick();
      end
      m_delay   = 1;
      req_valid = 4'hF;
      #1;
      chk("rw_ptr_zero", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      wait_res(n);
      chk("rw_latency", n, 2);
      chk("rw_id", res_id, 0);
      hs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
